// File: rtl/seg_pkg.sv
// Shared constants, types and helpers for the multiplexed 7-segment scan controller.
// Segment and anode values are active-low throughout.

package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0]            SEG_OFF = 8'hFF;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'hF;

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_t;

    // Active-low one-hot anode pattern: only the selected digit is pulled low.
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input digit_t d);
        logic [NUM_DIGITS-1:0] a;
        a    = AN_OFF;
        a[d] = 1'b0;
        return a;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter and digit index for the display scan; flags the blank window,
// the last cycle of each slot and the frame boundary (last cycle of the last digit).

module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       in_blank,
    output logic       slot_end,
    output logic       frame_end,
    output logic [1:0] digit
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the always_ff blocks are evaluated.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            digit <= '0;
        end else if (slot_end) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

    assign slot_end  = (cnt == LAST);
    assign frame_end = slot_end && (digit == 2'(NUM_DIGITS - 1));

    // A zero-length blank window would make the compare a constant, so drop it.
    generate
        if (BLANK_CYC > 0) begin : g_blank
            assign in_blank = (cnt < CW'(BLANK_CYC));
        end else begin : g_no_blank
            assign in_blank = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit 7-segment scan controller with tear-free shadow/active frame commit.
// Optional feature macro SEG_DIM_EN adds the `bright` input and PWM dimming.

module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
`ifdef SEG_DIM_EN
    input  logic [3:0] bright,
`endif
    output logic       pending,
    output logic       frame_done,
    output logic [3:0] anodo,
    output logic [7:0] catodo
);

    logic       in_blank;
    logic       slot_end;
    logic       frame_end;
    logic [1:0] digit;

    logic [7:0] shadow_q  [NUM_DIGITS];
    logic [7:0] shadow_nxt[NUM_DIGITS];
    logic [7:0] active_q  [NUM_DIGITS];

    logic   copy_now;
    logic   pwm_on;
    logic   drive_en;
    phase_t phase;

    seg_slot_timer #(
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .in_blank  (in_blank),
        .slot_end  (slot_end),
        .frame_end (frame_end),
        .digit     (digit)
    );

    // Shadow as it will be after this edge, so a write on the boundary cycle
    // lands in the same copy that publishes the frame.
    // NOTE: every always_comb output gets a full default before any conditional
    // update; a missing branch would otherwise infer a latch.
    always_comb begin
        shadow_nxt = shadow_q;
        if (wr_en) begin
            shadow_nxt[wr_addr] = wr_data;
        end
    end

    assign copy_now = frame_end && (pending || commit);

    // NOTE: the buffers are only four registers and their blank-display value is
    // observable after reset, so they are reset explicitly rather than left as RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= SEG_OFF;
                active_q[i] <= SEG_OFF;
            end
        end else begin
            shadow_q <= shadow_nxt;
            if (copy_now) begin
                active_q <= shadow_nxt;
            end
        end
    end

    // Boundary wins over a same-cycle commit: the copy consumes it immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (copy_now) begin
            pending <= 1'b0;
        end else if (commit) begin
            pending <= 1'b1;
        end
    end

`ifdef SEG_DIM_EN
    logic [3:0] pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm <= 4'd0;
        end else begin
            pwm <= pwm + 4'd1;
        end
    end

    assign pwm_on = (pwm <= bright);
`else
    assign pwm_on = 1'b1;
`endif

    always_comb begin
        phase    = in_blank ? BLANK : DRIVE;
        drive_en = (phase == DRIVE) && pwm_on;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anodo      <= AN_OFF;
            catodo     <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            anodo      <= drive_en ? anode_sel(digit) : AN_OFF;
            catodo     <= drive_en ? active_q[digit]  : SEG_OFF;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random traffic,
// every cycle compared against a cycle-count based reference model.

module tb_seg_scan_ctrl;

`ifdef SEG_DIM_EN
    localparam int P = 64;
    localparam int B = 4;
`else
    localparam int P = 8;
    localparam int B = 2;
`endif
    localparam int ND    = 4;
    localparam int FRAME = P * ND;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
`ifdef SEG_DIM_EN
    logic [3:0] bright;
`endif
    logic       pending;
    logic       frame_done;
    logic [3:0] anodo;
    logic [7:0] catodo;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .PRESCALE  (P),
        .BLANK_CYC (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
`ifdef SEG_DIM_EN
        .bright     (bright),
`endif
        .pending    (pending),
        .frame_done (frame_done),
        .anodo      (anodo),
        .catodo     (catodo)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: time since reset release plus the two pattern buffers.
    int         t;
    logic [7:0] m_shadow[ND];
    logic [7:0] m_active[ND];
    logic       m_pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, got, exp, t, $time);
        end
    endtask

    task automatic model_reset();
        t         = 0;
        m_pending = 1'b0;
        for (int i = 0; i < ND; i++) begin
            m_shadow[i] = 8'hFF;
            m_active[i] = 8'hFF;
        end
    endtask

    // One clock: predict this cycle's registered outputs, clock, compare, advance model.
    task automatic step();
        int         c;
        int         d;
        logic       boundary;
        logic       drive;
        logic       copy;
        logic       exp_pending;
        logic [3:0] exp_an;
        logic [7:0] exp_cat;

        c        = t % P;
        d        = (t / P) % ND;
        boundary = (d == ND - 1) && (c == P - 1);
        drive    = (c >= B);
`ifdef SEG_DIM_EN
        if ((t % 16) > int'(bright)) drive = 1'b0;
`endif
        exp_an  = 4'hF;
        exp_cat = 8'hFF;
        if (drive) begin
            exp_an[d] = 1'b0;
            exp_cat   = m_active[d];
        end

        if (wr_en) m_shadow[wr_addr] = wr_data;
        copy        = boundary && (m_pending || commit);
        exp_pending = copy ? 1'b0 : (m_pending || commit);

        @(posedge clk);
        #1;
        check("anodo",      anodo,      exp_an);
        check("catodo",     catodo,     exp_cat);
        check("frame_done", frame_done, boundary);
        check("pending",    pending,    exp_pending);

        if (copy) begin
            for (int i = 0; i < ND; i++) m_active[i] = m_shadow[i];
        end
        m_pending = exp_pending;
        t++;
    endtask

    task automatic cycle(input logic we, input logic [1:0] a, input logic [7:0] dat, input logic cm);
        wr_en   = we;
        wr_addr = a;
        wr_data = dat;
        commit  = cm;
        step();
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 8'h00, 1'b0);
    endtask

    // Idle until the next cycle is at the given offset within the frame (bounded).
    task automatic run_to(input int target);
        for (int i = 0; i < FRAME; i++) begin
            if ((t % FRAME) == target) break;
            cycle(1'b0, 2'd0, 8'h00, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_anodo",      anodo,      4'hF);
        check("rst_catodo",     catodo,     8'hFF);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_pending",    pending,    1'b0);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 8'h00;
        commit  = 1'b0;
`ifdef SEG_DIM_EN
        bright  = 4'd15;
`endif
        model_reset();
        do_reset();

        // Blank then digit 0 with empty pattern; frame_done cadence.
        idle(2 * FRAME);

        // Two digits written, commit mid-frame, shown from the next frame.
        run_to(FRAME / 2);
        cycle(1'b1, 2'd0, 8'hC0, 1'b0);
        cycle(1'b1, 2'd1, 8'hF9, 1'b0);
        cycle(1'b0, 2'd0, 8'h00, 1'b1);
        idle(2 * FRAME);

        // Write without commit stays hidden; later commit publishes it.
        cycle(1'b1, 2'd3, 8'hA4, 1'b0);
        idle(3 * FRAME);
        cycle(1'b0, 2'd0, 8'h00, 1'b1);
        idle(2 * FRAME);

        // Commit and write together on the exact boundary cycle.
        run_to(FRAME - 1);
        cycle(1'b1, 2'd2, 8'hB0, 1'b1);
        idle(2 * FRAME);

        // Reset during digit-2 DRIVE with a commit pending.
        run_to(P + 1);
        cycle(1'b1, 2'd1, 8'h99, 1'b1);
        run_to(2 * P + B + 1);
        do_reset();
        idle(FRAME);
        cycle(1'b0, 2'd0, 8'h00, 1'b1);
        idle(2 * FRAME);

`ifdef SEG_DIM_EN
        bright = 4'd3;
        idle(FRAME);
        bright = 4'd15;
        idle(FRAME);
`endif

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
`ifdef SEG_DIM_EN
            if ($urandom_range(0, 199) == 0) bright = 4'($urandom);
`endif
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0, 2'($urandom), 8'($urandom),
                      $urandom_range(0, 40) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
